// File: rtl/apb_req_arbiter.sv
// -----------------------------------------------------------------------------
// apb_req_arbiter
//
// Shares one APB master between two command requesters using round-robin
// arbitration. One command is in flight at a time: it is accepted in IDLE,
// presented to the master for the whole of BUSY, and answered with a single
// response pulse in DONE. A watchdog aborts transfers that never complete.
//
// Ports
//   pclk            clock, all state changes on the rising edge
//   preset          asynchronous active-low reset
//   req_valid[1:0]  per-port command request, held until req_ready
//   req_write[1:0]  per-port direction (1 = write, 0 = read)
//   req_addr0/1     per-port address (bit 32 is the master's slave select)
//   req_wdata0/1    per-port write data
//   req_ready[1:0]  one-hot pulse: command accepted this cycle
//   resp_valid[1:0] one-hot pulse: owner's transfer finished
//   resp_rdata      read data, valid with resp_valid (0 for writes/errors)
//   resp_err        error flag, valid with resp_valid
//   m_transfer      transfer request to the APB master
//   m_read_write    direction to the APB master
//   m_write_addr    write address to the APB master
//   m_read_addr     read address to the APB master
//   m_write_data    write data to the APB master
//   m_penable       access-phase indicator from the master
//   m_pready        slave ready
//   m_prdata        slave read data
//   m_pslverr       slave error from the master
// -----------------------------------------------------------------------------
module apb_req_arbiter #(
    parameter int ADDR_W  = 33,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_write,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        req_ready,
    output logic [1:0]        resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              m_transfer,
    output logic              m_read_write,
    output logic [ADDR_W-1:0] m_write_addr,
    output logic [ADDR_W-1:0] m_read_addr,
    output logic [DATA_W-1:0] m_write_data,
    input  logic              m_penable,
    input  logic              m_pready,
    input  logic [DATA_W-1:0] m_prdata,
    input  logic              m_pslverr
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Watchdog value seen in the last allowed BUSY cycle.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [1:0]        state_reg;
    logic [1:0]        state_next;
    logic              last_grant_reg;
    logic              owner_reg;
    logic              wr_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [TO_W-1:0]   wd_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              err_reg;
    // Held low through reset and for the first clock after it, so that no
    // command can be accepted while the block is being held in reset.
    logic              run_reg;

    logic              grant_idx;
    logic              accept;
    logic              finish;
    logic [DATA_W-1:0] rdata_next;
    logic              err_next;
    logic              busy;

    logic [ADDR_W-1:0] port_addr  [2];
    logic [DATA_W-1:0] port_wdata [2];

    assign port_addr[0]  = req_addr0;
    assign port_addr[1]  = req_addr1;
    assign port_wdata[0] = req_wdata0;
    assign port_wdata[1] = req_wdata1;

    // Round-robin choice: a lone requester always wins; when both request,
    // the port that did not win last time is served.
    always_comb begin
        grant_idx = 1'b0;
        if (req_valid == 2'b11) begin
            grant_idx = ~last_grant_reg;
        end else if (req_valid[1]) begin
            grant_idx = 1'b1;
        end
    end

    assign accept = (state_reg == ST_IDLE) && run_reg && (req_valid != 2'b00);
    assign busy   = (state_reg == ST_BUSY);

    // Per-port handshake pulses.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign req_ready[gi]  = accept && (grant_idx == 1'(gi));
        assign resp_valid[gi] = (state_reg == ST_DONE) && (owner_reg == 1'(gi));
    end

    // Completion logic for BUSY. Slave error beats a normal handshake, and
    // both beat the watchdog, so a late but real completion is never
    // reported as a timeout.
    always_comb begin
        state_next = state_reg;
        finish     = 1'b0;
        rdata_next = '0;
        err_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (m_pslverr) begin
                    finish   = 1'b1;
                    err_next = 1'b1;
                end else if (m_penable && m_pready) begin
                    finish = 1'b1;
                    if (!wr_reg) begin
                        rdata_next = m_prdata;
                    end
                end else if (wd_reg == TO_LAST) begin
                    finish   = 1'b1;
                    err_next = 1'b1;
                end
                if (finish) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= 1'b1;
            owner_reg      <= 1'b0;
            wr_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            wd_reg         <= '0;
            rdata_reg      <= '0;
            err_reg        <= 1'b0;
            run_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;
            run_reg   <= 1'b1;

            if (accept) begin
                last_grant_reg <= grant_idx;
                owner_reg      <= grant_idx;
                wr_reg         <= req_write[grant_idx];
                addr_reg       <= port_addr[grant_idx];
                wdata_reg      <= port_wdata[grant_idx];
            end

            // Counts BUSY cycles only; any other state leaves it at zero,
            // so every command starts with a fresh budget.
            if (busy) begin
                wd_reg <= wd_reg + TO_W'(1);
            end else begin
                wd_reg <= '0;
            end

            if (finish) begin
                rdata_reg <= rdata_next;
                err_reg   <= err_next;
            end
        end
    end

    // Master-side outputs come straight from the latched command and the
    // state, so they are constant throughout BUSY and fall to zero the
    // moment reset is applied or the transfer ends.
    assign m_transfer   = busy;
    assign m_read_write = busy && wr_reg;
    assign m_write_addr = (busy && wr_reg)  ? addr_reg  : '0;
    assign m_read_addr  = (busy && !wr_reg) ? addr_reg  : '0;
    assign m_write_data = (busy && wr_reg)  ? wdata_reg : '0;

    // Response payload is only presented during the DONE pulse.
    assign resp_rdata = (state_reg == ST_DONE) ? rdata_reg : '0;
    assign resp_err   = (state_reg == ST_DONE) ? err_reg   : 1'b0;

endmodule
